// File: rtl/projectile_ctl_if.sv
// rtl/projectile_ctl_if.sv - control and position bundle between the throw controller and its user
// The master drives the throw request; the slave (controller) returns position and events.
interface projectile_ctl_if #(
  parameter int POS_W = 12
);
  logic                    enable;
  logic [9:0]              throw_force;
  logic [6:0]              wind;
  logic signed [POS_W-1:0] x_pos;
  logic signed [POS_W-1:0] y_pos;
  logic                    busy;
  logic                    hit_target;
  logic                    hit_wall;
  logic                    landed;

  modport master (
    output enable, throw_force, wind,
    input  x_pos, y_pos, busy, hit_target, hit_wall, landed
  );

  modport slave (
    input  enable, throw_force, wind,
    output x_pos, y_pos, busy, hit_target, hit_wall, landed
  );
endinterface

// File: rtl/projectile_ctl.sv
// rtl/projectile_ctl.sv - ballistic throw controller with rise/fall phases, wind, wall and target box
// Positions advance once per physics tick; all event pulses are registered one-cycle strobes.
module projectile_ctl #(
  parameter int POS_W     = 12,
  parameter int START_X   = 884,
  parameter int START_Y   = 350,
  parameter int DIR       = -1,
  parameter int V0        = 27,
  parameter int GRAVITY   = 1,
  parameter int FORCE_PCT = 18,
  parameter int TICK_DIV  = 1300000,
  parameter int GROUND_Y  = 243,
  parameter int WALL_XL   = 234,
  parameter int WALL_XR   = 278,
  parameter int WALL_TOP  = 527,
  parameter int MARGIN    = 15,
  parameter int TGT_XL    = 867,
  parameter int TGT_XR    = 1024,
  parameter int TGT_YB    = 243,
  parameter int TGT_YT    = 341
) (
  input  logic             clk,
  input  logic             rst_n,
  projectile_ctl_if.slave  bus
);

  localparam int CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int POS_MAX = (1 <<< (POS_W - 1)) - 1;
  localparam int POS_MIN = -(1 <<< (POS_W - 1));
  localparam logic signed [POS_W-1:0] START_XP = POS_W'(START_X);
  localparam logic signed [POS_W-1:0] START_YP = POS_W'(START_Y);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_END} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    tick;
  logic [15:0]             t_q, t_d, t_inc;
  logic                    en_q;
  logic [9:0]              force_q, force_d;
  logic [6:0]              wind_q, wind_d;
  logic signed [POS_W-1:0] x_q, x_d, y_q, y_d, xf_q, xf_d, yf_q, yf_d;
  logic                    hit_target_q, hit_target_d;
  logic                    hit_wall_q, hit_wall_d;
  logic                    landed_q, landed_d;
  logic                    tgt_done_q, tgt_done_d;

  int ti, vx, f, w, drop, x_cur, y_cur, nx, ny;
  logic move;

  function automatic logic signed [POS_W-1:0] sat(input int v);
    if (v > POS_MAX)      sat = POS_W'(POS_MAX);
    else if (v < POS_MIN) sat = POS_W'(POS_MIN);
    else                  sat = POS_W'(v);
  endfunction

  function automatic logic in_band(input int x);
    in_band = (x >= WALL_XL - MARGIN) && (x <= WALL_XR + MARGIN);
  endfunction

  function automatic logic in_box(input int x, input int y);
    in_box = (x >= TGT_XL) && (x <= TGT_XR) && (y >= TGT_YB) && (y <= TGT_YT);
  endfunction

  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign t_inc = (t_q == 16'hFFFF) ? t_q : t_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    force_d      = force_q;
    wind_d       = wind_q;
    x_d          = x_q;
    y_d          = y_q;
    xf_d         = xf_q;
    yf_d         = yf_q;
    hit_target_d = 1'b0;
    hit_wall_d   = 1'b0;
    landed_d     = 1'b0;
    tgt_done_d   = tgt_done_q;
    move         = 1'b0;
    nx           = 0;
    ny           = 0;

    ti    = int'({16'd0, t_inc});
    f     = int'({22'd0, force_q});
    w     = int'({25'd0, wind_q});
    vx    = DIR * ((f * FORCE_PCT) / 100) + ((w - 50) * f) / 50;
    drop  = (GRAVITY * ti * ti) / 2;
    x_cur = int'(x_q);
    y_cur = int'(y_q);

    case (state_q)
      S_IDLE: begin
        x_d = START_XP;
        y_d = START_YP;
        if (bus.enable && !en_q) begin
          state_d    = S_RISE;
          t_d        = '0;
          force_d    = bus.throw_force;
          wind_d     = (bus.wind > 7'd100) ? 7'd100 : bus.wind;
          tgt_done_d = 1'b0;
        end
      end
      S_RISE: if (tick) begin
        t_d = t_inc;
        // Apex reached: freeze the last risen point as the origin of the fall.
        if (V0 - GRAVITY * ti <= 0) begin
          state_d = S_FALL;
          t_d     = '0;
          xf_d    = x_q;
          yf_d    = y_q;
        end else begin
          move = 1'b1;
          nx   = START_X + vx * ti;
          ny   = START_Y + V0 * ti - drop;
        end
      end
      S_FALL: if (tick) begin
        t_d  = t_inc;
        move = 1'b1;
        ny   = int'(yf_q) - drop;
        // Below the wall top and inside its band the projectile slides down the wall face.
        nx   = (in_band(x_cur) && ny < WALL_TOP) ? x_cur : int'(xf_q) + vx * ti;
        if (in_band(nx) && ny >= WALL_TOP - MARGIN && ny <= WALL_TOP) begin
          hit_wall_d = 1'b1;
          state_d    = S_END;
        end else if (ny <= GROUND_Y) begin
          ny       = GROUND_Y;
          landed_d = 1'b1;
          state_d  = S_END;
        end
      end
      S_END: begin
        x_d = START_XP;
        y_d = START_YP;
        if (!bus.enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (move) begin
      x_d = sat(nx);
      y_d = sat(ny);
      if (in_box(int'(x_d), int'(y_d)) && !in_box(x_cur, y_cur) && !tgt_done_q) begin
        hit_target_d = 1'b1;
        tgt_done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      t_q          <= '0;
      en_q         <= 1'b0;
      force_q      <= '0;
      wind_q       <= '0;
      x_q          <= START_XP;
      y_q          <= START_YP;
      xf_q         <= START_XP;
      yf_q         <= START_YP;
      hit_target_q <= 1'b0;
      hit_wall_q   <= 1'b0;
      landed_q     <= 1'b0;
      tgt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= tick ? '0 : cnt_q + 1'b1;
      t_q          <= t_d;
      en_q         <= bus.enable;
      force_q      <= force_d;
      wind_q       <= wind_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xf_q         <= xf_d;
      yf_q         <= yf_d;
      hit_target_q <= hit_target_d;
      hit_wall_q   <= hit_wall_d;
      landed_q     <= landed_d;
      tgt_done_q   <= tgt_done_d;
    end
  end

  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.busy       = (state_q == S_RISE) || (state_q == S_FALL);
  assign bus.hit_target = hit_target_q;
  assign bus.hit_wall   = hit_wall_q;
  assign bus.landed     = landed_q;

endmodule
